// File: rtl/sar_avg_pkg.sv
// Shared definitions for the SAR sample averager: FSM state, accumulator sizing, parameter bounds.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sar_avg_pkg;

    // Averager control states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } sar_avg_state_t;

    // Legal range of AVG_LOG2 (0 means pass-through, 6 means 64-sample windows)
    localparam int AVG_LOG2_MIN = 0;
    localparam int AVG_LOG2_MAX = 6;

    // Accumulator must hold N full-scale codes: DATA + log2(N) bits
    function automatic int acc_width(input int data_w, input int avg_log2);
        return data_w + avg_log2;
    endfunction

endpackage

// File: rtl/sar_rise_detect.sv
// Turns the SAR controller's Ready level into a single-cycle sample event on its 0->1 edge.
// Latency: combinational event in the cycle Ready is first seen high; previous-value register updates every edge.
// Backpressure: none; a Ready held high produces exactly one event.
module sar_rise_detect (
    input  logic Clock,
    input  logic Reset,
    input  logic SarReady,
    output logic SampleEvent
);

    logic ready_prev;

    // Track the previous Ready level in every state so a level already high never looks like a new edge
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ready_prev <= 1'b0;
        end else begin
            ready_prev <= SarReady;
        end
    end

    assign SampleEvent = SarReady & ~ready_prev;

endmodule

// File: rtl/sar_sample_averager.sv
// Averages 2^AVG_LOG2 SAR conversion words and presents the mean via Valid/Ack; SAR_AVG_ROUND_EN selects round-half-up over truncation.
// Latency: AvgValid rises on the same edge that samples the Nth Ready rise.
// Backpressure: one-deep result register; a completion while an unacked result is held is dropped and flags sticky Overrun.
module sar_sample_averager
    import sar_avg_pkg::*;
#(
    parameter int DATA     = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Enable,
    input  logic            SarReady,
    input  logic [DATA-1:0] SarData,
    input  logic            AvgAck,
    output logic [DATA-1:0] AvgData,
    output logic            AvgValid,
    output logic            Overrun,
    output logic            Busy
);

    localparam int ACC_W = acc_width(DATA, AVG_LOG2);
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int N     = 1 << AVG_LOG2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    // Half an LSB of the result; N/2 is 0 in pass-through mode so rounding is a no-op there
`ifdef SAR_AVG_ROUND_EN
    localparam logic [ACC_W-1:0] ROUND_BIAS = ACC_W'(N / 2);
`else
    localparam logic [ACC_W-1:0] ROUND_BIAS = '0;
`endif

    sar_avg_state_t   state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sample_evt;
    logic             take;
    logic             done;
    logic [ACC_W-1:0] sum;
    logic [DATA-1:0]  result;

    sar_rise_detect u_rise (
        .Clock       (Clock),
        .Reset       (Reset),
        .SarReady    (SarReady),
        .SampleEvent (sample_evt)
    );

    // A sample counts only while running and still enabled; the Nth one closes the window
    always_comb begin
        take   = (state == ST_ACCUM) && Enable && sample_evt;
        done   = take && (cnt == CNT_LAST);
        sum    = acc + ACC_W'(SarData);
        // Max sum plus bias stays below N*2^DATA, so the shifted value always fits DATA bits
        result = DATA'((sum + ROUND_BIAS) >> AVG_LOG2);
    end

    // Run/stop FSM with accumulator, window counter and Busy; leaving ACCUM discards a partial window
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
            Busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    acc  <= '0;
                    cnt  <= '0;
                    Busy <= 1'b0;
                    if (Enable) begin
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (!Enable) begin
                        state <= ST_IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                        Busy  <= 1'b0;
                    end else if (take) begin
                        if (done) begin
                            // Clear on the completing edge so the very next rise starts a new window
                            acc  <= '0;
                            cnt  <= '0;
                            Busy <= 1'b0;
                        end else begin
                            acc  <= sum;
                            cnt  <= cnt + 1'b1;
                            Busy <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Result register with Valid/Ack handshake and sticky overrun; a same-cycle ack frees the slot for the new result
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            AvgData  <= '0;
            AvgValid <= 1'b0;
            Overrun  <= 1'b0;
        end else begin
            if (done) begin
                if (!AvgValid || AvgAck) begin
                    AvgData  <= result;
                    AvgValid <= 1'b1;
                end else begin
                    Overrun <= 1'b1;
                end
            end else if (AvgAck && AvgValid) begin
                AvgValid <= 1'b0;
            end
            // Overrun is only cleared once the block has actually stopped
            if (state == ST_IDLE) begin
                Overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sar_sample_averager.sv
module tb_sar_sample_averager;

    localparam int DATA     = 8;
    localparam int AVG_LOG2 = 2;
    localparam int N        = 1 << AVG_LOG2;

`ifdef SAR_AVG_ROUND_EN
    localparam bit ROUND = 1'b1;
    localparam int EXP_MIXED = 11;
`else
    localparam bit ROUND = 1'b0;
    localparam int EXP_MIXED = 10;
`endif

    logic            Clock;
    logic            Reset;
    logic            Enable;
    logic            SarReady;
    logic [DATA-1:0] SarData;
    logic            AvgAck;
    logic [DATA-1:0] AvgData;
    logic            AvgValid;
    logic            Overrun;
    logic            Busy;

    int n_cmp = 0;
    int n_bad = 0;

    sar_sample_averager #(.DATA(DATA), .AVG_LOG2(AVG_LOG2)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Enable   (Enable),
        .SarReady (SarReady),
        .SarData  (SarData),
        .AvgAck   (AvgAck),
        .AvgData  (AvgData),
        .AvgValid (AvgValid),
        .Overrun  (Overrun),
        .Busy     (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit m_prev  = 1'b0;
    bit m_accum = 1'b0;
    bit m_valid = 1'b0;
    bit m_over  = 1'b0;
    bit m_busy  = 1'b0;
    int m_data  = 0;
    int win[$];

    function automatic int mean_of(input int s);
        if (ROUND) return (s + N / 2) / N;
        return s / N;
    endfunction

    always @(posedge Clock or negedge Reset) begin : model
        bit evt;
        bit done;
        int s;
        if (!Reset) begin
            m_prev  = 1'b0;
            m_accum = 1'b0;
            m_valid = 1'b0;
            m_over  = 1'b0;
            m_busy  = 1'b0;
            m_data  = 0;
            win.delete();
        end else begin
            evt  = SarReady && !m_prev;
            done = 1'b0;
            if (m_accum && Enable && evt) begin
                win.push_back(int'(SarData));
                if (win.size() == N) begin
                    s = 0;
                    foreach (win[i]) s += win[i];
                    done = 1'b1;
                    if (!m_valid || AvgAck) begin
                        m_data  = mean_of(s);
                        m_valid = 1'b1;
                    end else begin
                        m_over = 1'b1;
                    end
                    win.delete();
                end
            end
            if (!done && AvgAck) m_valid = 1'b0;
            if (!m_accum) m_over = 1'b0;
            if (!Enable) win.delete();
            m_accum = Enable;
            m_prev  = SarReady;
            m_busy  = m_accum && (win.size() > 0);
        end
    end

    // Every falling edge the outputs must agree with the model
    always @(negedge Clock) begin
        chk("cyc_AvgData",  int'(AvgData),  m_data);
        chk("cyc_AvgValid", int'(AvgValid), int'(m_valid));
        chk("cyc_Overrun",  int'(Overrun),  int'(m_over));
        chk("cyc_Busy",     int'(Busy),     int'(m_busy));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic conv(input int d, input int hold);
        SarData  = DATA'(d);
        SarReady = 1'b1;
        step(hold);
        SarReady = 1'b0;
        step(2);
    endtask

    task automatic ack_pulse();
        AvgAck = 1'b1;
        step(1);
        AvgAck = 1'b0;
    endtask

    initial begin
        Reset    = 1'b1;
        Enable   = 1'b0;
        SarReady = 1'b0;
        SarData  = '0;
        AvgAck   = 1'b0;
        #2 Reset = 1'b0;
        step(2);
        chk("reset_AvgData",  int'(AvgData),  0);
        chk("reset_AvgValid", int'(AvgValid), 0);
        chk("reset_Overrun",  int'(Overrun),  0);
        chk("reset_Busy",     int'(Busy),     0);
        Reset = 1'b1;
        step(1);

        // Mixed window: truncation gives 10, rounding gives 11; check one-edge latency
        Enable = 1'b1;
        step(2);
        conv(10, 1);
        chk("mixed_busy", int'(Busy), 1);
        conv(11, 1);
        conv(11, 1);
        chk("mixed_pre_valid", int'(AvgValid), 0);
        SarData  = 8'd11;
        SarReady = 1'b1;
        step(1);
        chk("mixed_latency_valid", int'(AvgValid), 1);
        chk("mixed_data", int'(AvgData), EXP_MIXED);
        SarReady = 1'b0;
        step(2);
        ack_pulse();
        chk("mixed_acked", int'(AvgValid), 0);

        // Full-scale window must not wrap
        repeat (4) conv(255, 1);
        chk("full_data",  int'(AvgData),  255);
        chk("full_valid", int'(AvgValid), 1);
        ack_pulse();

        // Ready held high 3 cycles: one event per conversion, one result
        repeat (4) conv(40, 3);
        chk("held_data",  int'(AvgData),  40);
        chk("held_valid", int'(AvgValid), 1);
        ack_pulse();
        step(5);
        chk("held_single_result", int'(AvgValid), 0);

        // Overrun: second window completes while 20 is unread
        repeat (4) conv(20, 1);
        chk("ovr_first", int'(AvgData), 20);
        repeat (4) conv(8, 1);
        chk("ovr_kept_data", int'(AvgData),  20);
        chk("ovr_flag",      int'(Overrun),  1);
        Enable = 1'b0;
        step(2);
        chk("ovr_cleared",     int'(Overrun),  0);
        chk("ovr_valid_kept",  int'(AvgValid), 1);
        chk("ovr_data_kept",   int'(AvgData),  20);
        ack_pulse();
        Enable = 1'b1;
        step(2);

        // Ack in the same cycle as the next completion
        repeat (4) conv(25, 1);
        chk("ackcomp_first", int'(AvgData), 25);
        repeat (3) conv(30, 1);
        SarData  = 8'd30;
        SarReady = 1'b1;
        AvgAck   = 1'b1;
        step(1);
        AvgAck   = 1'b0;
        SarReady = 1'b0;
        chk("ackcomp_data",    int'(AvgData),  30);
        chk("ackcomp_valid",   int'(AvgValid), 1);
        chk("ackcomp_overrun", int'(Overrun),  0);
        step(2);

        // Asynchronous reset mid-window
        conv(100, 1);
        conv(100, 1);
        chk("rst_busy_before", int'(Busy), 1);
        #3 Reset = 1'b0;
        #1;
        chk("rst_AvgData",  int'(AvgData),  0);
        chk("rst_AvgValid", int'(AvgValid), 0);
        chk("rst_Overrun",  int'(Overrun),  0);
        chk("rst_Busy",     int'(Busy),     0);
        step(1);
        Reset = 1'b1;
        step(2);
        repeat (4) conv(4, 1);
        chk("rst_after_data",  int'(AvgData),  4);
        chk("rst_after_valid", int'(AvgValid), 1);
        ack_pulse();

        // Randomised traffic against the model
        Enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) Enable = ~Enable;
            if (SarReady) begin
                if ($urandom_range(0, 1) == 0) SarReady = 1'b0;
            end else if ($urandom_range(0, 99) < 35) begin
                SarReady = 1'b1;
            end
            SarData = DATA'($urandom_range(0, 255));
            AvgAck  = ($urandom_range(0, 99) < 25);
            step(1);
        end
        Enable   = 1'b0;
        SarReady = 1'b0;
        AvgAck   = 1'b0;
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
